// File: rtl/mem_accessor_if.sv
// Record types and the executor/writeback/bus interface of the memory-access stage.
package mem_accessor_pkg;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        is_lb;
    logic        is_lbu;
    logic        is_lh;
    logic        is_lhu;
    logic        is_lw;
    logic        is_sb;
    logic        is_sh;
    logic        is_sw;
  } executor_output;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        trap;
  } accessor_output;
endpackage

interface mem_accessor_if;
  import mem_accessor_pkg::*;
  logic           executor_valid;
  logic           accessor_ready;
  logic           accessor_valid;
  logic           writeback_ready;
  executor_output in;
  accessor_output out;
  logic           mem_valid;
  logic           mem_ready;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic [3:0]     mem_wstrb;
  logic [31:0]    mem_rdata;

  // Accessor side: consumes records, drives the bus.
  modport slave (
    input  executor_valid, writeback_ready, in, mem_ready, mem_rdata,
    output accessor_ready, accessor_valid, out, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
  // Environment side: executor, writeback and memory.
  modport master (
    output executor_valid, writeback_ready, in, mem_ready, mem_rdata,
    input  accessor_ready, accessor_valid, out, mem_valid, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_accessor.sv
// Memory-access stage: one record at a time, single-outstanding word bus,
// lane steering, sign extension, alignment trap and bus timeout trap.
module mem_accessor
  import mem_accessor_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_accessor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MEM, DONE} state_t;

  state_t         r_state, w_nxt;
  accessor_output r_out;
  logic [31:0]    r_mem_addr, r_wdata, r_cnt;
  logic [3:0]     r_wstrb;
  logic [4:0]     r_rd;
  logic [1:0]     r_off;
  logic           r_lb, r_lbu, r_lh, r_lhu, r_lw;

  logic        w_accept, w_is_load, w_is_mem, w_misal, w_expire, w_ld_any;
  logic [31:0] w_shift, w_ld_data;

  assign w_accept  = bus.executor_valid && (r_state == IDLE);
  assign w_is_load = bus.in.is_lb | bus.in.is_lbu | bus.in.is_lh | bus.in.is_lhu | bus.in.is_lw;
  assign w_is_mem  = w_is_load | bus.in.is_sb | bus.in.is_sh | bus.in.is_sw;
  assign w_misal   = ((bus.in.is_lh | bus.in.is_lhu | bus.in.is_sh) & bus.in.mem_addr[0]) |
                     ((bus.in.is_lw | bus.in.is_sw) & (|bus.in.mem_addr[1:0]));
  // Expiry on the TIMEOUT-th cycle of waiting; a zero TIMEOUT never expires.
  assign w_expire  = (TIMEOUT != 0) && (r_cnt == TIMEOUT - 32'd1);

  // Bring the addressed lane down to bit 0, then extend per access size.
  assign w_shift  = bus.mem_rdata >> {r_off, 3'b000};
  assign w_ld_any = r_lb | r_lbu | r_lh | r_lhu | r_lw;
  always_comb begin
    w_ld_data = w_shift;
    if (r_lb)       w_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
    else if (r_lbu) w_ld_data = {24'd0, w_shift[7:0]};
    else if (r_lh)  w_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
    else if (r_lhu) w_ld_data = {16'd0, w_shift[15:0]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // Next-state: bus access only for aligned memory records.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_nxt = (w_is_mem && !w_misal) ? MEM : DONE;
      MEM:  if (bus.mem_ready || w_expire) w_nxt = DONE;
      DONE: if (bus.writeback_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Datapath: latch the record on accept, build the bus request, capture the result.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out      <= '0;
      r_mem_addr <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_cnt      <= '0;
      r_rd       <= '0;
      r_off      <= '0;
      {r_lb, r_lbu, r_lh, r_lhu, r_lw} <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_rd  <= bus.in.rd;
          r_off <= bus.in.mem_addr[1:0];
          {r_lb, r_lbu, r_lh, r_lhu, r_lw} <=
            {bus.in.is_lb, bus.in.is_lbu, bus.in.is_lh, bus.in.is_lhu, bus.in.is_lw};
          if (!w_is_mem) begin
            r_out <= '{rd: bus.in.rd, rd_data: bus.in.rd_data, trap: 1'b0};
          end else if (w_misal) begin
            r_out <= '{rd: 5'd0, rd_data: 32'd0, trap: 1'b1};
          end else begin
            r_mem_addr <= {bus.in.mem_addr[31:2], 2'b00};
            r_cnt      <= '0;
            if (bus.in.is_sb) begin
              r_wdata <= {4{bus.in.mem_data[7:0]}};
              r_wstrb <= 4'b0001 << bus.in.mem_addr[1:0];
            end else if (bus.in.is_sh) begin
              r_wdata <= {2{bus.in.mem_data[15:0]}};
              r_wstrb <= 4'b0011 << bus.in.mem_addr[1:0];
            end else if (bus.in.is_sw) begin
              r_wdata <= bus.in.mem_data;
              r_wstrb <= 4'hF;
            end else begin
              r_wdata <= '0;
              r_wstrb <= '0;
            end
          end
        end
        MEM: begin
          // Completion takes priority over a same-cycle expiry.
          if (bus.mem_ready) begin
            if (w_ld_any) r_out <= '{rd: r_rd, rd_data: w_ld_data, trap: 1'b0};
            else          r_out <= '0;
          end else if (w_expire) begin
            r_out <= '{rd: 5'd0, rd_data: 32'd0, trap: 1'b1};
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.accessor_ready = (r_state == IDLE);
  assign bus.accessor_valid = (r_state == DONE);
  assign bus.mem_valid      = (r_state == MEM);
  assign bus.out            = r_out;
  assign bus.mem_addr       = r_mem_addr;
  assign bus.mem_wdata      = r_wdata;
  assign bus.mem_wstrb      = r_wstrb;

endmodule

// File: tb/tb_mem_accessor.sv
// Directed bench for mem_accessor (TIMEOUT=4): reset, pass-through, loads,
// stores, alignment traps, timeout, writeback stall and mid-access reset.
module tb_mem_accessor;
  import mem_accessor_pkg::*;

  localparam logic [7:0] F_LB = 8'h80, F_LBU = 8'h40, F_LH = 8'h20, F_LHU = 8'h10,
                         F_LW = 8'h08, F_SB = 8'h04, F_SH = 8'h02, F_SW = 8'h01;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_accessor_if ifc ();
  mem_accessor #(.TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(ifc.slave));

  always #5 clk = ~clk;

  function automatic executor_output mk(input logic [4:0] rd, input logic [31:0] rdd,
                                        input logic [31:0] addr, input logic [31:0] data,
                                        input logic [7:0] flags);
    return {rd, rdd, addr, data, flags};
  endfunction

  function automatic accessor_output ao(input logic [4:0] rd, input logic [31:0] d, input logic t);
    return {rd, d, t};
  endfunction

  // Present a record for one cycle; returns at the negedge after the accept edge.
  task automatic send(input executor_output r);
    @(negedge clk);
    ifc.in = r;
    ifc.executor_valid = 1'b1;
    @(negedge clk);
    ifc.executor_valid = 1'b0;
  endtask

  // Let writeback take the result, back to IDLE.
  task automatic drain();
    ifc.writeback_ready = 1'b1;
    @(negedge clk);
    ifc.writeback_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ifc.accessor_valid, ifc.mem_valid, ifc.mem_addr, ifc.mem_wdata, ifc.mem_wstrb, ifc.out} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got av=%b mv=%b addr=%h wd=%h ws=%h out=%h want all 0",
               ifc.accessor_valid, ifc.mem_valid, ifc.mem_addr, ifc.mem_wdata, ifc.mem_wstrb, ifc.out);
    end
    n_cmp++;
    if (ifc.accessor_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready got %b want 1", ifc.accessor_ready);
    end
    reset = 1'b1;
  endtask

  task automatic test_nonmem();
    send(mk(5'd5, 32'h1234, 32'h0, 32'h0, 8'h00));
    n_cmp++;
    if (ifc.accessor_valid !== 1'b1 || ifc.mem_valid !== 1'b0 || ifc.accessor_ready !== 1'b0) begin
      n_err++; $display("FAIL nonmem_hs got av=%b mv=%b ar=%b want 1 0 0",
                        ifc.accessor_valid, ifc.mem_valid, ifc.accessor_ready);
    end
    n_cmp++;
    if (ifc.out !== ao(5'd5, 32'h00001234, 1'b0)) begin
      n_err++; $display("FAIL nonmem_out got %h want %h", ifc.out, ao(5'd5, 32'h00001234, 1'b0));
    end
    drain();
    n_cmp++;
    if (ifc.accessor_ready !== 1'b1 || ifc.accessor_valid !== 1'b0) begin
      n_err++; $display("FAIL nonmem_release got ar=%b av=%b want 1 0", ifc.accessor_ready, ifc.accessor_valid);
    end
  endtask

  // One bus access: check request, hold mem_ready low for `waits` cycles, then complete.
  task automatic bus_access(input string nm, input executor_output r, input logic [31:0] rdata,
                            input int waits, input logic [31:0] e_addr, input logic [31:0] e_wd,
                            input logic [3:0] e_ws, input accessor_output e_out);
    ifc.mem_ready = 1'b0;
    send(r);
    n_cmp++;
    if (ifc.mem_valid !== 1'b1 || ifc.mem_addr !== e_addr || ifc.mem_wdata !== e_wd || ifc.mem_wstrb !== e_ws) begin
      n_err++; $display("FAIL %s_req got mv=%b addr=%h wd=%h ws=%b want 1 %h %h %b",
                        nm, ifc.mem_valid, ifc.mem_addr, ifc.mem_wdata, ifc.mem_wstrb, e_addr, e_wd, e_ws);
    end
    repeat (waits) @(negedge clk);
    n_cmp++;
    if (ifc.mem_valid !== 1'b1 || ifc.mem_addr !== e_addr || ifc.mem_wstrb !== e_ws) begin
      n_err++; $display("FAIL %s_hold got mv=%b addr=%h ws=%b want 1 %h %b",
                        nm, ifc.mem_valid, ifc.mem_addr, ifc.mem_wstrb, e_addr, e_ws);
    end
    ifc.mem_rdata = rdata;
    ifc.mem_ready = 1'b1;
    @(negedge clk);
    ifc.mem_ready = 1'b0;
    n_cmp++;
    if (ifc.mem_valid !== 1'b0 || ifc.accessor_valid !== 1'b1 || ifc.out !== e_out) begin
      n_err++; $display("FAIL %s_out got mv=%b av=%b out=%h want 0 1 %h",
                        nm, ifc.mem_valid, ifc.accessor_valid, ifc.out, e_out);
    end
    drain();
  endtask

  task automatic test_loads();
    bus_access("lb",  mk(5'd3, 32'h0, 32'h1003, 32'h0, F_LB),  32'h80AABBCC, 3, 32'h1000, 32'h0, 4'b0000, ao(5'd3, 32'hFFFFFF80, 1'b0));
    bus_access("lbu", mk(5'd4, 32'h0, 32'h1003, 32'h0, F_LBU), 32'h80AABBCC, 3, 32'h1000, 32'h0, 4'b0000, ao(5'd4, 32'h00000080, 1'b0));
    bus_access("lhu", mk(5'd6, 32'h0, 32'h1002, 32'h0, F_LHU), 32'h80AABBCC, 3, 32'h1000, 32'h0, 4'b0000, ao(5'd6, 32'h000080AA, 1'b0));
    bus_access("lh",  mk(5'd8, 32'h0, 32'h3002, 32'h0, F_LH),  32'h80AABBCC, 0, 32'h3000, 32'h0, 4'b0000, ao(5'd8, 32'hFFFF80AA, 1'b0));
    bus_access("lw",  mk(5'd9, 32'h0, 32'h3004, 32'h0, F_LW),  32'hCAFEF00D, 1, 32'h3004, 32'h0, 4'b0000, ao(5'd9, 32'hCAFEF00D, 1'b0));
  endtask

  task automatic test_stores();
    bus_access("sh", mk(5'd7, 32'h0, 32'h2002, 32'hDEADBEEF, F_SH), 32'h55555555, 1, 32'h2000, 32'hBEEFBEEF, 4'b1100, ao(5'd0, 32'h0, 1'b0));
    bus_access("sb", mk(5'd7, 32'h0, 32'h2001, 32'h000000A5, F_SB), 32'h0, 0, 32'h2000, 32'hA5A5A5A5, 4'b0010, ao(5'd0, 32'h0, 1'b0));
    // Ready on the 4th cycle coincides with expiry: completion must win.
    bus_access("sw", mk(5'd7, 32'h0, 32'h2008, 32'h11223344, F_SW), 32'h0, 3, 32'h2008, 32'h11223344, 4'b1111, ao(5'd0, 32'h0, 1'b0));
  endtask

  task automatic test_misaligned();
    executor_output recs[2];
    recs[0] = mk(5'd9, 32'h0, 32'h3001, 32'h0, F_LW);
    recs[1] = mk(5'd9, 32'h0, 32'h3001, 32'hFFFF, F_SH);
    for (int i = 0; i < 2; i++) begin
      send(recs[i]);
      n_cmp++;
      if (ifc.mem_valid !== 1'b0 || ifc.accessor_valid !== 1'b1 || ifc.out !== ao(5'd0, 32'h0, 1'b1)) begin
        n_err++; $display("FAIL misalign%0d got mv=%b av=%b out=%h want 0 1 %h",
                          i, ifc.mem_valid, ifc.accessor_valid, ifc.out, ao(5'd0, 32'h0, 1'b1));
      end
      drain();
    end
  endtask

  task automatic test_timeout();
    int n;
    ifc.mem_ready = 1'b0;
    send(mk(5'd2, 32'h0, 32'h4000, 32'h11223344, F_SW));
    n = 0;
    for (int i = 0; i < 10 && ifc.mem_valid === 1'b1; i++) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n !== 4) begin
      n_err++; $display("FAIL timeout_cycles got %0d want 4", n);
    end
    n_cmp++;
    if (ifc.accessor_valid !== 1'b1 || ifc.out !== ao(5'd0, 32'h0, 1'b1)) begin
      n_err++; $display("FAIL timeout_trap got av=%b out=%h want 1 %h", ifc.accessor_valid, ifc.out, ao(5'd0, 32'h0, 1'b1));
    end
    drain();
  endtask

  task automatic test_stall();
    send(mk(5'd11, 32'h00C0FFEE, 32'h0, 32'h0, 8'h00));
    ifc.in = mk(5'd12, 32'h0BADBAD0, 32'h0, 32'h0, 8'h00);
    ifc.executor_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (ifc.accessor_valid !== 1'b1 || ifc.accessor_ready !== 1'b0 || ifc.out !== ao(5'd11, 32'h00C0FFEE, 1'b0)) begin
        n_err++; $display("FAIL stall%0d got av=%b ar=%b out=%h want 1 0 %h",
                          i, ifc.accessor_valid, ifc.accessor_ready, ifc.out, ao(5'd11, 32'h00C0FFEE, 1'b0));
      end
      @(negedge clk);
    end
    ifc.executor_valid = 1'b0;
    drain();
    n_cmp++;
    if (ifc.accessor_valid !== 1'b0 || ifc.out !== ao(5'd11, 32'h00C0FFEE, 1'b0)) begin
      n_err++; $display("FAIL stall_release got av=%b out=%h want 0 %h",
                        ifc.accessor_valid, ifc.out, ao(5'd11, 32'h00C0FFEE, 1'b0));
    end
  endtask

  task automatic test_reset_in_mem();
    ifc.mem_ready = 1'b0;
    send(mk(5'd1, 32'h0, 32'h5004, 32'hA5A5A5A5, F_SW));
    n_cmp++;
    if (ifc.mem_valid !== 1'b1) begin
      n_err++; $display("FAIL rstmem_pre got mv=%b want 1", ifc.mem_valid);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ifc.accessor_valid, ifc.mem_valid, ifc.mem_addr, ifc.mem_wdata, ifc.mem_wstrb, ifc.out} !== '0) begin
      n_err++; $display("FAIL rstmem_outputs got av=%b mv=%b addr=%h wd=%h ws=%b out=%h want all 0",
                        ifc.accessor_valid, ifc.mem_valid, ifc.mem_addr, ifc.mem_wdata, ifc.mem_wstrb, ifc.out);
    end
    reset = 1'b1;
    ifc.mem_ready = 1'b1;
    @(negedge clk);
    ifc.mem_ready = 1'b0;
    n_cmp++;
    if (ifc.accessor_ready !== 1'b1 || ifc.accessor_valid !== 1'b0 || ifc.mem_valid !== 1'b0) begin
      n_err++; $display("FAIL rstmem_idle got ar=%b av=%b mv=%b want 1 0 0",
                        ifc.accessor_ready, ifc.accessor_valid, ifc.mem_valid);
    end
  endtask

  initial begin
    ifc.executor_valid  = 1'b0;
    ifc.writeback_ready = 1'b0;
    ifc.in              = '0;
    ifc.mem_ready       = 1'b0;
    ifc.mem_rdata       = '0;
    test_reset();
    test_nonmem();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_stall();
    test_reset_in_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_accessor.md
Name: mem_accessor

Overview:
- Memory-access pipeline stage. It is the consumer end of the executor's valid/ready output handshake.
- Accepts one executor_output record at a time and performs any load or store on a single-outstanding word-wide data bus (byte/half lane steering, sign extension, alignment check, bus timeout).
- Presents an accessor_output record to writeback.
- Sits between the executor and the writeback stage.

Parameters:
- TIMEOUT, default 255: maximum cycles mem_valid may wait for mem_ready before the access traps; 0 disables the timeout.

Ports:
- clk  input  1  clock, all logic on posedge
- reset  input  1  synchronous, active-low; 0 = reset
- executor_valid  input  1  upstream record valid
- accessor_ready  output  1  stage can accept a record this cycle
- accessor_valid  output  1  out record valid
- writeback_ready  input  1  downstream accepts out this cycle
- in  input  executor_output  fields: rd[4:0], rd_data[31:0], mem_addr[31:0], mem_data[31:0], is_lb/lbu/lh/lhu/lw/sb/sh/sw
- out  output  accessor_output  fields: rd[4:0], rd_data[31:0], trap
- mem_valid  output  1  bus request
- mem_ready  input  1  bus completion, valid only while mem_valid=1
- mem_addr  output  32  word address, bits[1:0] always 0
- mem_wdata  output  32  store data
- mem_wstrb  output  4  byte strobes; 0 = read
- mem_rdata  input  32  read data, sampled when mem_ready=1

Behaviour:
- Reset (reset=0 at a posedge): state=IDLE; all outputs 0 (accessor_valid, mem_valid, mem_addr, mem_wdata, mem_wstrb, out, timeout counter). This applies mid-transaction: mem_valid drops on that edge and the pending record is discarded.
- accessor_ready = (state==IDLE), combinational from state only.
- A record is accepted on a posedge with executor_valid && accessor_ready. Fields are latched; in is ignored at all other times.
- States: IDLE, MEM, DONE.
- IDLE, on accept, with non-memory record (no is_* flag set): out.rd=in.rd, out.rd_data=in.rd_data, trap=0; go to DONE. Latency 1 cycle.
- IDLE, on accept, with misaligned access: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0. Set out.rd=0, rd_data=0, trap=1; go to DONE; no bus cycle is issued.
- IDLE, on accept, with aligned memory access: mem_valid=1, mem_addr={addr[31:2],2'b00}, timeout counter=0; go to MEM.
  - Loads: wstrb=0, wdata=0.
  - sb: wdata={4{data[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - sh: wdata={2{data[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - sw: wdata=data, wstrb=4'hF.
- MEM: mem_addr, mem_wdata and mem_wstrb are held stable while mem_valid=1.
  - mem_ready=1: mem_valid=0; go to DONE with trap=0.
    - Loads: out.rd=rd; rd_data = selected lane of mem_rdata at byte offset addr[1:0]. lb/lh sign-extend, lbu/lhu zero-extend, lw takes all 32 bits.
    - Stores: out.rd=0, rd_data=0.
  - Else, if TIMEOUT!=0 and counter==TIMEOUT-1: mem_valid=0, out.rd=0, rd_data=0, trap=1; go to DONE.
  - Else: counter+1.
  - mem_ready on the same cycle as expiry: completion wins, no trap.
- DONE: accessor_valid=1 and out is held stable until writeback_ready=1. On that edge accessor_valid=0 and state returns to IDLE. A new record can be accepted no earlier than the following cycle, so throughput is at most 1 record per 2 cycles.
- mem_ready while mem_valid=0 is ignored.
- executor_valid while accessor_ready=0 is ignored; the producer must hold its record.
- Invariants:
  - mem_valid=1 iff state==MEM.
  - accessor_valid=1 iff state==DONE.
  - accessor_ready and accessor_valid are never both 1.

Test Plan:
- Reset, then non-memory record rd=5, rd_data=0x1234, writeback_ready=1 -> accessor_valid one cycle after accept; out={5, 0x00001234, 0}; no mem_valid.
- lb at addr 0x1003, mem_rdata=0x80AABBCC, mem_ready after 3 wait cycles -> mem_addr=0x1000, wstrb=0; out.rd_data=0xFFFFFF80. Same with lbu -> 0x00000080. lhu at 0x1002 -> 0x000080AA.
- sh at 0x2002, mem_data=0xDEADBEEF -> mem_wdata=0xBEEFBEEF, wstrb=4'b1100, mem_addr=0x2000; out.rd=0, trap=0.
- lw at 0x3001 -> no mem_valid ever; out.trap=1, rd=0 on next cycle. sh at 0x3001 -> trap. lh at 0x3002 -> normal bus cycle.
- TIMEOUT=4, sw with mem_ready never asserted -> mem_valid high exactly 4 cycles, then trap=1. Repeat with mem_ready on the 4th cycle -> no trap.
- writeback_ready held 0 for 5 cycles in DONE -> out stable, accessor_ready=0, executor_valid ignored. Reset driven low while in MEM -> mem_valid=0 and all outputs 0 on that edge.
